// File: rtl/acc_cu_pkg.sv
// Shared types and encodings for the accumulator control unit.
// Optional feature macro: CALL_RET_EN (enables CALL/RET on opcode E).
package acc_cu_pkg;

  typedef enum logic [1:0] {
    ST_FETCH    = 2'd0,
    ST_EXEC     = 2'd1,
    ST_FETCH_OP = 2'd2,
    ST_HALT     = 2'd3
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_LDR  = 4'h2;
  localparam logic [3:0] OP_STR  = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_OR   = 4'h7;
  localparam logic [3:0] OP_XOR  = 4'h8;
  localparam logic [3:0] OP_NOT  = 4'h9;
  localparam logic [3:0] OP_SHR  = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_JZ   = 4'hC;
  localparam logic [3:0] OP_JC   = 4'hD;
  localparam logic [3:0] OP_CALL = 4'hE;
  localparam logic [3:0] OP_HLT  = 4'hF;

  localparam logic [1:0] SEL_IMM = 2'b00;
  localparam logic [1:0] SEL_REG = 2'b01;
  localparam logic [1:0] SEL_ALU = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_NOT = 3'd5;
  localparam logic [2:0] ALU_SHR = 3'd6;

  // ALU opcodes are laid out contiguously from OP_ADD, matching the alu_op order.
  function automatic logic [2:0] alu_code(input logic [3:0] op);
    logic [3:0] d;
    d = op - OP_ADD;
    return d[2:0];
  endfunction

endpackage

// File: rtl/acc_cu_decode.sv
// Combinational decode: (state, opcode, flags) -> datapath strobes and next-state hint.
// Optional feature macro: CALL_RET_EN (opcode E decodes as CALL/RET).
module acc_cu_decode
  import acc_cu_pkg::*;
(
  input  state_t     state,
  input  logic [3:0] opcode,
`ifdef CALL_RET_EN
  input  logic       ret_sel,
  output logic       do_ret,
`endif
  input  logic       z,
  input  logic       c,
  output logic [1:0] sel_acc,
  output logic       load_acc,
  output logic       reg_write,
  output logic [2:0] alu_op,
  output logic       flag_we,
  output logic       fetch_req,
  output logic       branch_taken,
  output state_t     exec_next
);

  // Strobes are only non-zero in EXEC; branch decision is evaluated against held ir.
  always_comb begin
    sel_acc      = SEL_IMM;
    load_acc     = 1'b0;
    reg_write    = 1'b0;
    alu_op       = ALU_ADD;
    flag_we      = 1'b0;
    exec_next    = ST_FETCH;
    fetch_req    = (state == ST_FETCH) || (state == ST_FETCH_OP);
    branch_taken = 1'b0;
`ifdef CALL_RET_EN
    do_ret       = 1'b0;
`endif

    case (opcode)
      OP_JMP:  branch_taken = 1'b1;
      OP_JZ:   branch_taken = z;
      OP_JC:   branch_taken = c;
`ifdef CALL_RET_EN
      OP_CALL: branch_taken = ~ret_sel;
`endif
      default: branch_taken = 1'b0;
    endcase

    if (state == ST_EXEC) begin
      case (opcode)
        OP_LDI: begin
          sel_acc  = SEL_IMM;
          load_acc = 1'b1;
        end
        OP_LDR: begin
          sel_acc  = SEL_REG;
          load_acc = 1'b1;
        end
        OP_STR: reg_write = 1'b1;
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHR: begin
          sel_acc  = SEL_ALU;
          load_acc = 1'b1;
          alu_op   = alu_code(opcode);
          flag_we  = 1'b1;
        end
        OP_JMP, OP_JZ, OP_JC: exec_next = ST_FETCH_OP;
`ifdef CALL_RET_EN
        OP_CALL: begin
          if (ret_sel) do_ret = 1'b1;
          else         exec_next = ST_FETCH_OP;
        end
`endif
        OP_HLT:  exec_next = ST_HALT;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/acc_control_unit.sv
// Fetch/execute sequencer for the 8-bit accumulator datapath.
// Optional feature macro: CALL_RET_EN (single-entry CALL/RET on opcode E).
module acc_control_unit
  import acc_cu_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              clb,
  input  logic              run,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_rd,
  input  logic [7:0]        imem_data,
  input  logic              imem_ready,
  output logic [1:0]        SelAcc,
  output logic              LoadAcc,
  output logic [3:0]        Imm,
  output logic [REG_AW-1:0] Reg_addr,
  output logic              RegWrite,
  output logic [2:0]        alu_op,
  input  logic              alu_zero,
  input  logic              alu_carry,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  state_t            state;
  logic [7:0]        ir;
  logic              z_flag;
  logic              c_flag;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] target;

  logic [1:0]        dec_sel;
  logic              dec_load;
  logic              dec_regw;
  logic [2:0]        dec_alu;
  logic              flag_we;
  logic              fetch_req;
  logic              branch_taken;
  state_t            exec_next;

`ifdef CALL_RET_EN
  logic [ADDR_W-1:0] ret_reg;
  logic              do_ret;
`endif

  assign pc_inc = pc + ADDR_W'(1);
  assign target = ADDR_W'(imem_data);

  acc_cu_decode u_decode (
    .state        (state),
    .opcode       (ir[7:4]),
`ifdef CALL_RET_EN
    .ret_sel      (ir[0]),
    .do_ret       (do_ret),
`endif
    .z            (z_flag),
    .c            (c_flag),
    .sel_acc      (dec_sel),
    .load_acc     (dec_load),
    .reg_write    (dec_regw),
    .alu_op       (dec_alu),
    .flag_we      (flag_we),
    .fetch_req    (fetch_req),
    .branch_taken (branch_taken),
    .exec_next    (exec_next)
  );

  // Strobes and fetch request are forced inactive while clb is low, whatever the state.
  assign imem_addr = pc;
  assign imem_rd   = clb & fetch_req;
  assign LoadAcc   = clb & dec_load;
  assign RegWrite  = clb & dec_regw;
  assign SelAcc    = clb ? dec_sel : SEL_IMM;
  assign alu_op    = clb ? dec_alu : ALU_ADD;
  assign Imm       = ir[3:0];
  assign Reg_addr  = ir[REG_AW-1:0];
  assign halted    = (state == ST_HALT);

  // Sequencer: state, PC, instruction register, flags and return register.
  always_ff @(posedge clk) begin
    if (!clb) begin
      state  <= ST_FETCH;
      pc     <= '0;
      ir     <= '0;
      z_flag <= 1'b0;
      c_flag <= 1'b0;
`ifdef CALL_RET_EN
      ret_reg <= '0;
`endif
    end else begin
      case (state)
        ST_FETCH: begin
          if (imem_ready) begin
            ir    <= imem_data;
            pc    <= pc_inc;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (flag_we) begin
            z_flag <= alu_zero;
            c_flag <= alu_carry;
          end
`ifdef CALL_RET_EN
          if (do_ret) pc <= ret_reg;
`endif
          state <= exec_next;
        end
        ST_FETCH_OP: begin
          if (imem_ready) begin
            pc <= branch_taken ? target : pc_inc;
`ifdef CALL_RET_EN
            if (ir[7:4] == OP_CALL) ret_reg <= pc_inc;
`endif
            state <= ST_FETCH;
          end
        end
        ST_HALT: begin
          if (run) state <= ST_FETCH;
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_control_unit.sv
// Self-checking bench for acc_control_unit: instruction-level reference model
// driven cycle by cycle, a directed program with literal expectations, then random programs.
// Honours CALL_RET_EN when defined for the build.
module tb_acc_control_unit;

  logic       clk = 1'b0;
  logic       clb, run, imem_rd, imem_ready, LoadAcc, RegWrite, alu_zero, alu_carry, halted;
  logic [7:0] imem_addr, imem_data, pc;
  logic [1:0] SelAcc;
  logic [3:0] Imm, Reg_addr;
  logic [2:0] alu_op;

  always #5 clk = ~clk;

  acc_control_unit #(.ADDR_W(8), .REG_AW(4)) dut (
    .clk(clk), .clb(clb), .run(run), .imem_addr(imem_addr), .imem_rd(imem_rd),
    .imem_data(imem_data), .imem_ready(imem_ready), .SelAcc(SelAcc), .LoadAcc(LoadAcc),
    .Imm(Imm), .Reg_addr(Reg_addr), .RegWrite(RegWrite), .alu_op(alu_op),
    .alu_zero(alu_zero), .alu_carry(alu_carry), .pc(pc), .halted(halted)
  );

  typedef struct packed {
    logic       full;
    logic       rd;
    logic [7:0] addr;
    logic [1:0] sel;
    logic       load;
    logic       regw;
    logic [2:0] aluop;
    logic [3:0] imm;
    logic       halted;
    logic [7:0] pc;
  } exp_t;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [7:0] mem [256];
  logic [7:0] m_pc, m_ir, m_ret;
  logic       m_z, m_c;
  bit         rand_mode = 0;
  bit         inject_rst = 0;
  int         stall_forced = 0;
  logic       fz = 0, fc = 0;
  logic [1:0] snap_sel, ex_sel;
  logic       snap_load, ex_load;
  logic [2:0] snap_aluop, ex_aluop;
  logic [3:0] snap_imm, ex_imm;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t idle();
    exp_t e;
    e = '0;
    e.full = 1'b1;
    e.imm  = m_ir[3:0];
    e.pc   = m_pc;
    return e;
  endfunction

  // One clock cycle: inputs already driven, outputs compared at the negedge.
  task automatic step(input exp_t e);
    @(negedge clk);
    chk("imem_rd", {15'd0, imem_rd}, {15'd0, e.rd});
    if (e.rd) chk("imem_addr", {8'd0, imem_addr}, {8'd0, e.addr});
    chk("LoadAcc", {15'd0, LoadAcc}, {15'd0, e.load});
    chk("RegWrite", {15'd0, RegWrite}, {15'd0, e.regw});
    chk("SelAcc", {14'd0, SelAcc}, {14'd0, e.sel});
    chk("alu_op", {13'd0, alu_op}, {13'd0, e.aluop});
    if (e.full) begin
      chk("pc", {8'd0, pc}, {8'd0, e.pc});
      chk("halted", {15'd0, halted}, {15'd0, e.halted});
      chk("Imm", {12'd0, Imm}, {12'd0, e.imm});
      chk("Reg_addr", {12'd0, Reg_addr}, {12'd0, e.imm});
    end
    snap_sel = SelAcc; snap_load = LoadAcc; snap_aluop = alu_op; snap_imm = Imm;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_pc = 8'h00; m_ir = 8'h00; m_z = 1'b0; m_c = 1'b0; m_ret = 8'h00;
  endtask

  task automatic reset_cycle();
    exp_t e;
    e = '0;
    clb = 1'b0; imem_ready = $urandom; imem_data = $urandom; run = $urandom;
    step(e);
    clb = 1'b1;
    model_reset();
  endtask

  function automatic logic pick_rdy();
    if (stall_forced > 0) begin
      stall_forced--;
      return 1'b0;
    end
    if (rand_mode) return ($urandom_range(3) != 0);
    return 1'b1;
  endfunction

  // Fetch the byte at m_pc, tolerating any number of not-ready cycles.
  task automatic fetch_byte(output logic [7:0] b, output int n);
    exp_t e;
    logic r;
    n = 0;
    do begin
      r = pick_rdy();
      imem_ready = r;
      imem_data  = r ? mem[m_pc] : 8'($urandom);
      run = $urandom; alu_zero = $urandom; alu_carry = $urandom;
      e = idle();
      e.rd = 1'b1;
      e.addr = m_pc;
      step(e);
      n++;
    end while (!r);
    b = mem[m_pc];
  endtask

  // Execute one instruction at the ISA level, checking every cycle it takes.
  task automatic exec_instr(output int cyc);
    logic [7:0] b, t;
    logic [3:0] op;
    exp_t e;
    bit two, is_ret, taken;
    int n, hc;
    cyc = 0;
    fetch_byte(b, n);
    cyc += n;
    m_ir = b;
    m_pc = m_pc + 8'd1;
    op = b[7:4];
    two = (op == 4'hB) || (op == 4'hC) || (op == 4'hD);
    is_ret = 0;
`ifdef CALL_RET_EN
    if (op == 4'hE) begin
      if (b[0]) is_ret = 1;
      else      two = 1;
    end
`endif
    e = idle();
    if (op == 4'h1) begin e.sel = 2'b00; e.load = 1'b1; end
    else if (op == 4'h2) begin e.sel = 2'b01; e.load = 1'b1; end
    else if (op == 4'h3) e.regw = 1'b1;
    else if (op >= 4'h4 && op <= 4'hA) begin
      e.sel = 2'b10; e.load = 1'b1; e.aluop = 3'(op - 4'h4);
    end
    imem_ready = $urandom; imem_data = $urandom; run = $urandom;
    alu_zero  = rand_mode ? 1'($urandom) : fz;
    alu_carry = rand_mode ? 1'($urandom) : fc;
    step(e);
    cyc++;
    ex_sel = snap_sel; ex_load = snap_load; ex_aluop = snap_aluop; ex_imm = snap_imm;
    if (op >= 4'h4 && op <= 4'hA) begin
      m_z = alu_zero;
      m_c = alu_carry;
    end
    if (is_ret) m_pc = m_ret;
    if (op == 4'hF) begin
      hc = 0;
      do begin
        run = rand_mode ? ($urandom_range(2) == 0) : (hc == 2);
        if (hc >= 20) run = 1'b1;
        imem_ready = $urandom; imem_data = $urandom;
        e = idle();
        e.halted = 1'b1;
        step(e);
        cyc++;
        hc++;
      end while (!run);
    end
    if (two) begin
      if (inject_rst) begin
        inject_rst = 0;
        reset_cycle();
        cyc++;
        return;
      end
      fetch_byte(t, n);
      cyc += n;
      taken = (op == 4'hB) || (op == 4'hC && m_z) || (op == 4'hD && m_c) || (op == 4'hE);
      if (op == 4'hE) m_ret = m_pc + 8'd1;
      m_pc = taken ? t : m_pc + 8'd1;
    end
    inject_rst = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    exp_t e;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h15; mem[8'h01] = 8'hC0; mem[8'h02] = 8'h20;
    mem[8'h03] = 8'h43; mem[8'h04] = 8'h17; mem[8'h05] = 8'hC0; mem[8'h06] = 8'h20;
    mem[8'h20] = 8'hD0; mem[8'h21] = 8'hFF; mem[8'hFF] = 8'hB0;
    mem[8'h15] = 8'hF0; mem[8'h16] = 8'hB0; mem[8'h17] = 8'h10;
    mem[8'h10] = 8'hE0; mem[8'h11] = 8'h40; mem[8'h40] = 8'hE1;
    mem[8'h12] = 8'h32; mem[8'h13] = 8'hB0; mem[8'h14] = 8'h55;

    clb = 1'b0; run = 1'b0; imem_ready = 1'b0; imem_data = 8'h00;
    alu_zero = 1'b0; alu_carry = 1'b0;
    e = '0;
    step(e);
    step(e);
    clb = 1'b1;
    model_reset();

    exec_instr(cyc);                      // 00: LDI 5
    chk("lit_ldi_pc", {8'd0, pc}, 16'h0001);
    chk("lit_ldi_imm", {12'd0, ex_imm}, 16'h0005);
    chk("lit_ldi_load", {15'd0, ex_load}, 16'h0001);
    chk("lit_ldi_sel", {14'd0, ex_sel}, 16'h0000);
    chk("lit_ldi_cycles", cyc[15:0], 16'd2);
    exec_instr(cyc);                      // 01: JZ 20, Z=0
    chk("lit_jz_nt_pc", {8'd0, pc}, 16'h0003);
    chk("lit_jz_nt_cycles", cyc[15:0], 16'd3);
    fz = 1'b1; fc = 1'b1;
    exec_instr(cyc);                      // 03: ADD r3 with zero/carry set
    chk("lit_add_sel", {14'd0, ex_sel}, 16'h0002);
    chk("lit_add_aluop", {13'd0, ex_aluop}, 16'h0000);
    fz = 1'b0; fc = 1'b0;
    exec_instr(cyc);                      // 04: LDI 7, flags must hold
    chk("lit_ldi2_pc", {8'd0, pc}, 16'h0005);
    exec_instr(cyc);                      // 05: JZ 20, Z=1
    chk("lit_jz_t_pc", {8'd0, pc}, 16'h0020);
    exec_instr(cyc);                      // 20: JC FF, C=1
    chk("lit_jc_t_pc", {8'd0, pc}, 16'h00FF);
    exec_instr(cyc);                      // FF: JMP, operand wraps to 00
    chk("lit_jmp_wrap_pc", {8'd0, pc}, 16'h0015);
    exec_instr(cyc);                      // 15: HLT, run after two idle cycles
    chk("lit_hlt_pc", {8'd0, pc}, 16'h0016);
    chk("lit_hlt_cycles", cyc[15:0], 16'd5);
    exec_instr(cyc);                      // 16: JMP 10
    chk("lit_jmp_pc", {8'd0, pc}, 16'h0010);
    exec_instr(cyc);                      // 10: CALL 40 (or NOP)
`ifdef CALL_RET_EN
    chk("lit_call_pc", {8'd0, pc}, 16'h0040);
`else
    chk("lit_e0_nop_pc", {8'd0, pc}, 16'h0011);
`endif
    exec_instr(cyc);                      // 40: RET (or 11: ADD r0)
    chk("lit_ret_pc", {8'd0, pc}, 16'h0012);
    stall_forced = 3;
    exec_instr(cyc);                      // 12: STR r2 with 3 stall cycles
    chk("lit_stall_cycles", cyc[15:0], 16'd5);
    chk("lit_stall_pc", {8'd0, pc}, 16'h0013);
    inject_rst = 1;
    exec_instr(cyc);                      // 13: JMP, reset during operand fetch
    chk("lit_rst_pc", {8'd0, pc}, 16'h0000);

    rand_mode = 1;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int k = 0; k < 400; k++) begin
      inject_rst = ($urandom_range(39) == 0);
      exec_instr(cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
